// File: rtl/param_slave_fifo.sv
// Parameterised single-clock slave FIFO: upstream write port, arbiter-acked read port
// with one-cycle registered read data, occupancy/margin/almost-full status and sticky underflow.
module param_slave_fifo #(
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned DEPTH    = 32,
  parameter int unsigned AFULL_TH = 28,
  localparam int unsigned AW      = $clog2(DEPTH),
  localparam int unsigned CW      = AW + 1
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              chx_valid_i,
  input  logic [DATA_W-1:0] chx_data_i,
  input  logic              slvx_en_i,
  input  logic              flush_i,
  input  logic              a2sx_ack_i,
  output logic              chx_ready_o,
  output logic              slvx_req_o,
  output logic              slvx_val_o,
  output logic [DATA_W-1:0] slvx_data_o,
  output logic [CW-1:0]     margin_o,
  output logic [CW-1:0]     count_o,
  output logic              afull_o,
  output logic              udf_o
);

  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [CW-1:0] AFULL_C = CW'(AFULL_TH);

  logic [DATA_W-1:0] mem_q [DEPTH];

  logic [CW-1:0]     wptr_q, wptr_d;
  logic [CW-1:0]     rptr_q, rptr_d;
  logic              val_q, val_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              udf_q, udf_d;

  logic              empty, full, wr_en, rd_en;
  logic [CW-1:0]     count;

  // Pointers carry an extra wrap bit so full and empty are distinguishable.
  assign empty = (wptr_q == rptr_q);
  assign full  = (wptr_q[AW-1:0] == rptr_q[AW-1:0]) && (wptr_q[AW] != rptr_q[AW]);
  assign count = wptr_q - rptr_q;

  assign chx_ready_o = !full && slvx_en_i && !flush_i && !rst_i;
  assign slvx_req_o  = !empty && !rst_i;
  assign wr_en       = chx_valid_i && chx_ready_o;
  assign rd_en       = a2sx_ack_i && !empty && !flush_i;

  assign count_o     = count;
  assign margin_o    = DEPTH_C - count;
  assign afull_o     = (count >= AFULL_C);
  assign slvx_val_o  = val_q;
  assign slvx_data_o = data_q;
  assign udf_o       = udf_q;

  // Storage is intentionally not reset.
  always_ff @(posedge clk_i) begin
    if (wr_en) begin
      mem_q[wptr_q[AW-1:0]] <= chx_data_i;
    end
  end

  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    val_d  = 1'b0;
    data_d = data_q;
    udf_d  = udf_q;
    if (flush_i) begin
      wptr_d = '0;
      rptr_d = '0;
      udf_d  = 1'b0;
    end else begin
      if (wr_en) begin
        wptr_d = wptr_q + CW'(1);
      end
      if (rd_en) begin
        rptr_d = rptr_q + CW'(1);
        val_d  = 1'b1;
        data_d = mem_q[rptr_q[AW-1:0]];
      end
      if (a2sx_ack_i && empty) begin
        udf_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wptr_q <= '0;
      rptr_q <= '0;
      val_q  <= 1'b0;
      data_q <= '0;
      udf_q  <= 1'b0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      val_q  <= val_d;
      data_q <= data_d;
      udf_q  <= udf_d;
    end
  end

endmodule

// File: doc/param_slave_fifo.md
PARAM_SLAVE_FIFO -- requirements
Module: param_slave_fifo

Interface
REQ-001 Parameter DATA_W, default 32, data word width in bits (1..64).
REQ-002 Parameter DEPTH, default 32, entry count; SHALL be a power of two, 4..1024.
REQ-003 Parameter AFULL_TH, default 28, almost-full threshold in entries (1..DEPTH).
REQ-004 Derived AW = log2(DEPTH); count/margin width CW = AW+1.
REQ-005 clk_i  input  1  single clock, all state on rising edge.
REQ-006 rst_i  input  1  reset, asynchronous assert, active-high.
REQ-007 chx_valid_i  input  1  upstream data valid.
REQ-008 chx_data_i  input  DATA_W  upstream data.
REQ-009 slvx_en_i  input  1  channel enable from register block.
REQ-010 flush_i  input  1  synchronous flush, discards all contents.
REQ-011 a2sx_ack_i  input  1  arbiter read acknowledge.
REQ-012 chx_ready_o  output  1  upstream may transfer this cycle.
REQ-013 slvx_req_o  output  1  FIFO non-empty, request to arbiter.
REQ-014 slvx_val_o  output  1  slvx_data_o valid, one-cycle pulse per read.
REQ-015 slvx_data_o  output  DATA_W  registered read data.
REQ-016 margin_o  output  CW  free entries, DEPTH - count.
REQ-017 count_o  output  CW  occupied entries.
REQ-018 afull_o  output  1  count_o >= AFULL_TH.
REQ-019 udf_o  output  1  sticky: ack received while empty.

Function
REQ-020 Storage: DEPTH x DATA_W array; write/read pointers CW bits wide, address = low AW bits, MSB = wrap bit.
REQ-021 empty when pointers equal; full when low AW bits equal and wrap bits differ.
REQ-022 count = wptr - rptr modulo 2^CW; count_o, margin_o, afull_o combinational from registered pointers.
REQ-023 chx_ready_o = !full && slvx_en_i && !flush_i, combinational.
REQ-024 Write: chx_valid_i && chx_ready_o -> mem[wptr] <= chx_data_i, wptr+1 on the same edge.
REQ-025 slvx_req_o = !empty, combinational; 0 while rst_i high.
REQ-026 Read: a2sx_ack_i && !empty && !flush_i -> slvx_data_o <= mem[rptr], rptr+1, slvx_val_o <= 1 next cycle; else slvx_val_o <= 0, slvx_data_o holds.
REQ-027 Read latency: data appears exactly one cycle after accepted ack; back-to-back acks give back-to-back valid pulses.
REQ-028 Simultaneous read and write when neither full nor empty: both proceed, count unchanged.
REQ-029 Full: writes blocked even with a same-cycle read (ready depends on registered state only).
REQ-030 Empty: no bypass; a write landing in the cycle of an ack is not read that cycle.
REQ-031 Pointer wrap from 2^CW-1 to 0 SHALL be seamless; count arithmetic stays correct across wrap.
REQ-032 slvx_en_i low blocks writes only; reads continue draining.
REQ-033 flush_i high: next edge wptr=rptr=0, slvx_val_o=0, udf_o=0; flush beats same-cycle read and write.
REQ-034 udf_o sets on a2sx_ack_i && empty && !flush_i; stays set until flush or reset.
REQ-035 Memory array not reset; contents undefined until written.

Reset
REQ-036 rst_i high asynchronously forces wptr=0, rptr=0, slvx_val_o=0, slvx_data_o=0, udf_o=0.
REQ-037 During reset: chx_ready_o=0, slvx_req_o=0, count_o=0, margin_o=DEPTH, afull_o=0.
REQ-038 Reset mid-transfer drops all stored data; first post-reset write goes to address 0.

Verification
REQ-039 Defaults, write 32 words 0..31 with ack low -> chx_ready_o 0 after 32nd, margin_o 0, count_o 32, afull_o 1 from count 28.
REQ-040 From full, ack 32 consecutive cycles -> slvx_val_o high 32 cycles, data 0..31 in order, slvx_req_o 0 after last accept.
REQ-041 Continuous write+ack for 100 words at one-entry occupancy -> pointers wrap, in-order data, count_o never exceeds 1.
REQ-042 Ack with FIFO empty -> no valid pulse, udf_o 1 and held; flush_i one cycle -> udf_o 0, count_o 0.
REQ-043 Load 10 words, assert rst_i between edges -> outputs reset immediately; next write+ack returns new word, not stale data.
REQ-044 DEPTH=4, AFULL_TH=3, DATA_W=8 -> afull_o at count 3, full at 4, margin_o width 3.
